// File: rtl/elem_ca_engine_if.sv
// elem_ca_engine_if: control/status bundle between a controller and the CA engine
//   master (controller): drives load/data/rule/wrap/start/steps, observes q/busy/done/stable/gen_count
//   slave  (engine)    : the reverse
interface elem_ca_engine_if #(
    parameter int WIDTH = 512,
    parameter int CNT_W = 16
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic [7:0]       rule;
    logic             wrap;
    logic             start;
    logic [CNT_W-1:0] steps;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             stable;
    logic [CNT_W-1:0] gen_count;

    modport master (
        output load, data, rule, wrap, start, steps,
        input  q, busy, done, stable, gen_count
    );

    modport slave (
        input  load, data, rule, wrap, start, steps,
        output q, busy, done, stable, gen_count
    );
endinterface

// File: rtl/elem_ca_engine.sv
// elem_ca_engine: bounded-run 1-D elementary cellular automaton, any Wolfram rule, zero or toroidal boundary
//   clk     : rising-edge clock
//   aresetn : asynchronous active-low reset
//   bus     : slave side of elem_ca_engine_if (load/start control in, cell state and run status out)
module elem_ca_engine #(
    parameter int WIDTH = 512,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    elem_ca_engine_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cells_q, cells_d, next_gen;
    logic [WIDTH+1:0] ext;
    logic [7:0]       rule_q, rule_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] gen_q, gen_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    // Pad the row with its boundary neighbours so every cell sees {L,C,R} = ext[i+2:i]
    assign ext = {wrap_q & cells_q[0], cells_q, wrap_q & cells_q[WIDTH-1]};

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            assign next_gen[i] = rule_q[ext[i+2 -: 3]];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cells_d  = cells_q;
        rule_d   = rule_q;
        wrap_d   = wrap_q;
        done_d   = 1'b0;
        stable_d = stable_q;
        gen_d    = gen_q;
        rem_d    = rem_q;
        if (bus.load) begin
            cells_d  = bus.data;
            rule_d   = bus.rule;
            wrap_d   = bus.wrap;
            state_d  = IDLE;
            stable_d = 1'b0;
            gen_d    = '0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                gen_d    = '0;
                stable_d = 1'b0;
                rem_d    = bus.steps;
                // A zero-length run completes immediately without entering RUN
                done_d   = (bus.steps == '0);
                state_d  = (bus.steps == '0) ? IDLE : RUN;
            end
        end else begin
            cells_d = next_gen;
            gen_d   = gen_q + CNT_W'(1);
            rem_d   = rem_q - CNT_W'(1);
            // A fixed point ends the run early; the no-op generation still counts
            if (next_gen == cells_q) begin
                stable_d = 1'b1;
                state_d  = IDLE;
                done_d   = 1'b1;
            end else if (rem_q == CNT_W'(1)) begin
                stable_d = 1'b0;
                state_d  = IDLE;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            cells_q  <= '0;
            rule_q   <= '0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
            stable_q <= 1'b0;
            gen_q    <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            cells_q  <= cells_d;
            rule_q   <= rule_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
            stable_q <= stable_d;
            gen_q    <= gen_d;
            rem_q    <= rem_d;
        end
    end

    assign bus.q         = cells_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.stable    = stable_q;
    assign bus.gen_count = gen_q;
endmodule

// File: tb/tb_elem_ca_engine.sv
// tb_elem_ca_engine: scoreboard bench for elem_ca_engine at WIDTH=8 and WIDTH=512
module tb_elem_ca_engine;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    elem_ca_engine_if #(.WIDTH(8),   .CNT_W(CW)) s_if ();
    elem_ca_engine_if #(.WIDTH(512), .CNT_W(CW)) b_if ();

    elem_ca_engine #(.WIDTH(8),   .CNT_W(CW)) dut_s (.clk(clk), .aresetn(aresetn), .bus(s_if.slave));
    elem_ca_engine #(.WIDTH(512), .CNT_W(CW)) dut_b (.clk(clk), .aresetn(aresetn), .bus(b_if.slave));

    int vectors = 0;
    int errors  = 0;
    logic [511:0] exp_q[$];

    function automatic logic [511:0] legacy110(input logic [511:0] c);
        logic [511:0] l, r;
        l = c >> 1;
        r = c << 1;
        return (c | r) & ~(l & c & r);
    endfunction

    task automatic load_s(input logic [7:0] d, input logic [7:0] r, input logic w);
        s_if.load = 1'b1; s_if.data = d; s_if.rule = r; s_if.wrap = w;
        @(negedge clk);
        s_if.load = 1'b0;
    endtask

    task automatic start_s(input logic [CW-1:0] n);
        s_if.start = 1'b1; s_if.steps = n;
        @(negedge clk);
        s_if.start = 1'b0;
    endtask

    task automatic test_reset;
        vectors++; if (s_if.q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", s_if.q); end
        vectors++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", s_if.busy); end
        vectors++; if (s_if.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", s_if.done); end
        vectors++; if (s_if.stable !== 1'b0) begin errors++; $display("FAIL reset_stable got %b want 0", s_if.stable); end
        vectors++; if (s_if.gen_count !== '0) begin errors++; $display("FAIL reset_gen got %0d want 0", s_if.gen_count); end
        vectors++; if (b_if.q !== '0) begin errors++; $display("FAIL reset_q512 not zero"); end
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rule110;
        logic [7:0] e;
        load_s(8'h01, 8'd110, 1'b0);
        vectors++; if (s_if.q !== 8'h01) begin errors++; $display("FAIL r110_load got %h want 01", s_if.q); end
        exp_q.push_back(512'h03);
        exp_q.push_back(512'h07);
        start_s(2);
        vectors++; if (s_if.busy !== 1'b1) begin errors++; $display("FAIL r110_busy got %b want 1", s_if.busy); end
        vectors++; if (s_if.q !== 8'h01) begin errors++; $display("FAIL r110_accept_q got %h want 01", s_if.q); end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front()[7:0];
            vectors++; if (s_if.q !== e) begin errors++; $display("FAIL r110_q got %h want %h", s_if.q, e); end
            vectors++; if (s_if.done !== (exp_q.size() == 0)) begin errors++; $display("FAIL r110_done got %b want %b", s_if.done, exp_q.size() == 0); end
        end
        vectors++; if (s_if.gen_count !== 16'd2) begin errors++; $display("FAIL r110_gen got %0d want 2", s_if.gen_count); end
        vectors++; if (s_if.stable !== 1'b0) begin errors++; $display("FAIL r110_stable got %b want 0", s_if.stable); end
        vectors++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL r110_busy_end got %b want 0", s_if.busy); end
        @(negedge clk);
        vectors++; if (s_if.done !== 1'b0) begin errors++; $display("FAIL r110_done_pulse got %b want 0", s_if.done); end
    endtask

    task automatic test_rule90_boundary;
        logic [7:0] e;
        for (int w = 1; w >= 0; w--) begin
            load_s(8'h01, 8'd90, w[0]);
            exp_q.push_back(w ? 512'h82 : 512'h02);
            start_s(1);
            @(negedge clk);
            e = exp_q.pop_front()[7:0];
            vectors++; if (s_if.q !== e) begin errors++; $display("FAIL r90_wrap%0d_q got %h want %h", w, s_if.q, e); end
            vectors++; if (s_if.done !== 1'b1) begin errors++; $display("FAIL r90_wrap%0d_done got %b want 1", w, s_if.done); end
            vectors++; if (s_if.gen_count !== 16'd1) begin errors++; $display("FAIL r90_wrap%0d_gen got %0d want 1", w, s_if.gen_count); end
        end
    endtask

    task automatic test_fixed_point;
        logic [7:0] e;
        load_s(8'hFF, 8'd0, 1'b0);
        exp_q.push_back(512'h0);
        exp_q.push_back(512'h0);
        start_s(10);
        @(negedge clk);
        e = exp_q.pop_front()[7:0];
        vectors++; if (s_if.q !== e) begin errors++; $display("FAIL fp_q1 got %h want %h", s_if.q, e); end
        vectors++; if (s_if.done !== 1'b0) begin errors++; $display("FAIL fp_done1 got %b want 0", s_if.done); end
        vectors++; if (s_if.busy !== 1'b1) begin errors++; $display("FAIL fp_busy1 got %b want 1", s_if.busy); end
        @(negedge clk);
        e = exp_q.pop_front()[7:0];
        vectors++; if (s_if.q !== e) begin errors++; $display("FAIL fp_q2 got %h want %h", s_if.q, e); end
        vectors++; if (s_if.done !== 1'b1) begin errors++; $display("FAIL fp_done2 got %b want 1", s_if.done); end
        vectors++; if (s_if.stable !== 1'b1) begin errors++; $display("FAIL fp_stable got %b want 1", s_if.stable); end
        vectors++; if (s_if.gen_count !== 16'd2) begin errors++; $display("FAIL fp_gen got %0d want 2", s_if.gen_count); end
        vectors++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL fp_busy2 got %b want 0", s_if.busy); end
    endtask

    task automatic test_zero_steps;
        load_s(8'h5A, 8'd110, 1'b0);
        start_s(0);
        vectors++; if (s_if.done !== 1'b1) begin errors++; $display("FAIL zs_done got %b want 1", s_if.done); end
        vectors++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL zs_busy got %b want 0", s_if.busy); end
        vectors++; if (s_if.q !== 8'h5A) begin errors++; $display("FAIL zs_q got %h want 5a", s_if.q); end
        vectors++; if (s_if.gen_count !== '0) begin errors++; $display("FAIL zs_gen got %0d want 0", s_if.gen_count); end
        @(negedge clk);
        vectors++; if (s_if.done !== 1'b0) begin errors++; $display("FAIL zs_done_clear got %b want 0", s_if.done); end
        vectors++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL zs_busy2 got %b want 0", s_if.busy); end
    endtask

    task automatic test_legacy512;
        logic [511:0] d, nd, m, e;
        for (int k = 0; k < 16; k++) begin d[k*32 +: 32] = $urandom; nd[k*32 +: 32] = $urandom; end
        b_if.load = 1'b1; b_if.data = d; b_if.rule = 8'd110; b_if.wrap = 1'b0;
        @(negedge clk);
        b_if.load = 1'b0;
        b_if.start = 1'b1; b_if.steps = 16'd100;
        @(negedge clk);
        b_if.start = 1'b0;
        m = d;
        for (int g = 1; g <= 50; g++) begin
            m = legacy110(m);
            exp_q.push_back(m);
            if (g == 20) begin b_if.start = 1'b1; b_if.steps = 16'd3; end
            @(negedge clk);
            b_if.start = 1'b0;
            e = exp_q.pop_front();
            vectors++; if (b_if.q !== e) begin errors++; $display("FAIL leg_q gen %0d differs from legacy model", g); end
            vectors++; if (b_if.busy !== 1'b1 || b_if.done !== 1'b0) begin errors++; $display("FAIL leg_status gen %0d busy=%b done=%b want busy=1 done=0", g, b_if.busy, b_if.done); end
        end
        vectors++; if (b_if.gen_count !== 16'd50) begin errors++; $display("FAIL leg_gen got %0d want 50", b_if.gen_count); end
        b_if.load = 1'b1; b_if.data = nd;
        @(negedge clk);
        b_if.load = 1'b0;
        vectors++; if (b_if.q !== nd) begin errors++; $display("FAIL leg_load_q not new data"); end
        vectors++; if (b_if.busy !== 1'b0) begin errors++; $display("FAIL leg_load_busy got %b want 0", b_if.busy); end
        vectors++; if (b_if.gen_count !== '0) begin errors++; $display("FAIL leg_load_gen got %0d want 0", b_if.gen_count); end
        for (int c = 0; c < 4; c++) begin
            vectors++; if (b_if.done !== 1'b0) begin errors++; $display("FAIL leg_load_done cycle %0d got %b want 0", c, b_if.done); end
            @(negedge clk);
        end
        vectors++; if (b_if.q !== nd) begin errors++; $display("FAIL leg_idle_q changed after abort"); end
    endtask

    task automatic test_async_reset;
        load_s(8'h5A, 8'd110, 1'b0);
        start_s(20);
        repeat (3) @(negedge clk);
        vectors++; if (s_if.busy !== 1'b1) begin errors++; $display("FAIL ar_busy_before got %b want 1", s_if.busy); end
        #2 aresetn = 1'b0;
        #1;
        vectors++; if (s_if.q !== 8'h00) begin errors++; $display("FAIL ar_q got %h want 00", s_if.q); end
        vectors++; if (s_if.busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b want 0", s_if.busy); end
        vectors++; if (s_if.gen_count !== '0) begin errors++; $display("FAIL ar_gen got %0d want 0", s_if.gen_count); end
        vectors++; if (s_if.done !== 1'b0) begin errors++; $display("FAIL ar_done got %b want 0", s_if.done); end
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        start_s(5);
        @(negedge clk);
        vectors++; if (s_if.done !== 1'b1) begin errors++; $display("FAIL ar_run_done got %b want 1", s_if.done); end
        vectors++; if (s_if.stable !== 1'b1) begin errors++; $display("FAIL ar_run_stable got %b want 1", s_if.stable); end
        vectors++; if (s_if.gen_count !== 16'd1) begin errors++; $display("FAIL ar_run_gen got %0d want 1", s_if.gen_count); end
        vectors++; if (s_if.q !== 8'h00) begin errors++; $display("FAIL ar_run_q got %h want 00", s_if.q); end
    endtask

    initial begin
        s_if.load = 1'b0; s_if.data = '0; s_if.rule = '0; s_if.wrap = 1'b0; s_if.start = 1'b0; s_if.steps = '0;
        b_if.load = 1'b0; b_if.data = '0; b_if.rule = '0; b_if.wrap = 1'b0; b_if.start = 1'b0; b_if.steps = '0;
        @(negedge clk);
        test_reset();
        test_rule110();
        test_rule90_boundary();
        test_fixed_point();
        test_zero_steps();
        test_legacy512();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/elem_ca_engine.md
Name: elem_ca_engine

Overview:
- Parametrised one-dimensional elementary cellular-automaton engine. Successor to the fixed rule-110, fixed-512-bit, free-running stepper.
- Any of the 256 Wolfram rules is selectable at load time. Cell width and boundary mode are configurable.
- Runs a bounded number of generations under a start/busy/done handshake and stops early on a fixed point.
- Sits as a self-contained compute block driven by a controller that loads a pattern, starts a run and reads back q.

Parameters:
- WIDTH, 512, number of cells (≥3).
- CNT_W, 16, width of the step-count and generation-count fields.

Ports:
- clk  input  1  rising-edge clock.
- aresetn  input  1  asynchronous active-low reset.
- load  input  1  load data, rule and wrap; aborts any run.
- data  input  WIDTH  initial cell pattern.
- rule  input  8  Wolfram rule number, sampled on load.
- wrap  input  1  boundary mode, sampled on load: 0 = zero boundary, 1 = toroidal.
- start  input  1  request a run; accepted only when idle.
- steps  input  CNT_W  generations to run, sampled with an accepted start.
- q  output  WIDTH  current cell state.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse on run completion.
- stable  output  1  last run ended on a fixed point; valid from done until the next accepted start or load.
- gen_count  output  CNT_W  generations applied in the current or last run.

Behaviour:
- Reset (aresetn low, asynchronous):
  - q=0, rule_r=0, wrap_r=0, busy=0, done=0, stable=0, gen_count=0, remaining=0, state IDLE.
- Next-state function, for cell i:
  - next[i] = rule_r[{L,C,R}], where L=q[i+1], C=q[i], R=q[i-1].
  - Zero boundary: q[WIDTH] and q[-1] read as 0.
  - Wrap boundary: q[WIDTH] = q[0] and q[-1] = q[WIDTH-1].
  - Fully combinational. One generation per clock.
  - rule_r=110 with wrap_r=0 must reproduce the legacy rule-110 block bit-exactly.
- States: IDLE and RUN. done is a registered pulse, not a state.
- load:
  - Highest priority in any state.
  - Effect: q<=data, rule_r<=rule, wrap_r<=wrap, state<=IDLE, busy<=0, stable<=0, gen_count<=0.
  - No done pulse is generated.
  - load and start in the same cycle: start is ignored.
- IDLE, start=1 and load=0:
  - If steps==0: done<=1 next cycle, gen_count<=0, stable<=0, busy stays 0, q unchanged.
  - Otherwise: remaining<=steps, gen_count<=0, stable<=0, busy<=1, state<=RUN. q is not updated on this edge.
- RUN, each edge with load=0:
  - q<=next, gen_count<=gen_count+1, remaining<=remaining-1.
  - If next==q: stable<=1, state<=IDLE, busy<=0, done<=1. The no-op generation is still counted.
  - Else if remaining==1: state<=IDLE, busy<=0, done<=1, stable<=0.
- start while busy is ignored, and steps is not resampled.
- Latency: a run of N generations with no fixed point asserts done exactly N cycles after the accepting edge. busy is high for exactly N cycles.
- done is high for one cycle only. It is cleared on the following edge regardless of inputs.
- gen_count never exceeds steps; no wrap-around handling is required.
- Reset asserted mid-run: immediate return to the reset values. No done pulse.

Test Plan:
1. WIDTH=8, load data=0x01, rule=110, wrap=0; start steps=2 -> q goes 0x03 then 0x07; done pulses 2 cycles after start; gen_count=2; stable=0.
2. WIDTH=8, load data=0x01, rule=90 -> with wrap=1, steps=1: q=0x82. Reload with wrap=0, steps=1: q=0x02.
3. WIDTH=8, load data=0xFF, rule=0; start steps=10 -> q=0x00 after the first generation; done after the second; gen_count=2; stable=1.
4. steps=0 start -> done pulses the next cycle; busy never rises; q and gen_count=0 unchanged.
5. WIDTH=512, rule=110, wrap=0, random data; steps=100 -> q matches the legacy rule-110 model every cycle. Assert load at generation 50 -> q=new data, busy=0, no done pulse. Assert start while busy -> ignored.
6. Drop aresetn mid-run (asynchronously, between edges) -> q, busy, gen_count are 0 immediately. After release, start with no load -> all-zero pattern under rule 0 -> stable=1 at gen_count=1.
